// File: rtl/line_rx.sv
// line_rx: oversampling serial line receiver (start, 8 data LSB first, optional parity, stop)
module line_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_data,
    input  logic [1:0] i_verify_mode,
    output logic [7:0] o_data,
    output logic       o_rx_int,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t      state, state_n;
    logic        s1, s2, rxs;
    logic [1:0]  sync_fill;
    logic        armed;
    logic [CW-1:0] cnt;
    logic        tick;
    logic [2:0]  bc;
    logic [7:0]  sh;
    logic [1:0]  mode_q;
    logic        perr_q;
    logic        exp_par;

    assign rxs  = s2;
    assign tick = cnt == '0;

    // expected parity bit for the latched mode over the fully shifted byte
    always_comb exp_par = mode_q == 2'b01 ? ~^sh : mode_q == 2'b10 ? ^sh : 1'b1;

    // state register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;

    // next-state: each bit-period state advances on the mid-bit sample tick
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = armed && !rxs ? START : IDLE;
            START:   state_n = !tick ? START : rxs ? IDLE : DATA;
            DATA:    state_n = tick && bc == 3'd7 ? (mode_q == 2'b00 ? STOP : PARITY) : DATA;
            PARITY:  state_n = tick ? STOP : PARITY;
            STOP:    state_n = !tick ? STOP : rxs ? IDLE : BREAK;
            BREAK:   state_n = rxs ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    // synchronizer, sample timing, shift register and registered frame status
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1           <= 1'b1;
            s2           <= 1'b1;
            sync_fill    <= 2'b00;
            armed        <= 1'b0;
            cnt          <= '0;
            bc           <= 3'd0;
            sh           <= 8'h00;
            mode_q       <= 2'b00;
            perr_q       <= 1'b0;
            o_data       <= 8'h00;
            o_rx_int     <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            s1        <= i_rx_data;
            s2        <= s1;
            // the reset value of the synchronizer is not a real line sample,
            // so arming waits until both stages hold captured line data
            sync_fill <= {sync_fill[0], 1'b1};
            o_rx_int  <= 1'b0;
            if (state == IDLE && rxs && sync_fill[1])
                armed <= 1'b1;
            cnt <= state == IDLE ? CW'(H - 1) : tick ? CW'(CLKS_PER_BIT - 1) : cnt - 1'b1;
            if (state == IDLE && state_n == START)
                mode_q <= i_verify_mode;
            if (state == START)
                bc <= 3'd0;
            if (state == DATA && tick) begin
                sh[bc] <= rxs;
                bc     <= bc + 3'd1;
            end
            if (state == PARITY && tick)
                perr_q <= rxs != exp_par;
            if (state == STOP && tick) begin
                o_data       <= sh;
                o_parity_err <= mode_q != 2'b00 && perr_q;
                o_frame_err  <= ~rxs;
                o_rx_int     <= 1'b1;
            end
            o_busy <= state_n != IDLE;
        end
    end
endmodule
